// File: rtl/fpu_stream_pkg.sv
// rtl/fpu_stream_pkg.sv - shared types and source ids for the stream arbiter
package fpu_stream_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  typedef logic [1:0] src_id_t;

  localparam src_id_t SRC_A = 2'd0;
  localparam src_id_t SRC_B = 2'd1;
  localparam src_id_t SRC_C = 2'd2;
  localparam src_id_t SRC_D = 2'd3;

endpackage

// File: rtl/stream_arbiter_if.sv
// rtl/stream_arbiter_if.sv - requester and sink handshake bundle of the stream arbiter
interface stream_arbiter_if #(
  parameter int WIDTH = 32
);
  import fpu_stream_pkg::*;

  logic [WIDTH-1:0] input_a;
  logic [WIDTH-1:0] input_b;
  logic [WIDTH-1:0] input_c;
  logic [WIDTH-1:0] input_d;
  logic             input_a_stb;
  logic             input_b_stb;
  logic             input_c_stb;
  logic             input_d_stb;
  logic             input_a_ack;
  logic             input_b_ack;
  logic             input_c_ack;
  logic             input_d_ack;
  logic [WIDTH-1:0] output_z;
  src_id_t          output_z_src;
  logic             output_z_stb;
  logic             output_z_ack;
  logic             busy;

  modport slave (
    input  input_a, input_b, input_c, input_d,
    input  input_a_stb, input_b_stb, input_c_stb, input_d_stb,
    output input_a_ack, input_b_ack, input_c_ack, input_d_ack,
    output output_z, output_z_src, output_z_stb,
    input  output_z_ack,
    output busy
  );

  modport master (
    output input_a, input_b, input_c, input_d,
    output input_a_stb, input_b_stb, input_c_stb, input_d_stb,
    input  input_a_ack, input_b_ack, input_c_ack, input_d_ack,
    input  output_z, output_z_src, output_z_stb,
    output output_z_ack,
    input  busy
  );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - 4-way round-robin pick starting just after the last owner
module rr_arbiter
  import fpu_stream_pkg::*;
(
  input  logic [3:0] req,
  input  src_id_t    last,
  output logic       valid,
  output src_id_t    pick
);

  logic    found;
  src_id_t idx;

  // Offset 4 wraps back to the last owner itself, so it only wins when alone.
  always_comb begin
    pick  = last;
    found = 1'b0;
    idx   = last;
    for (int k = 1; k <= 4; k++) begin
      idx = last + src_id_t'(k);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/stream_arbiter.sv
// rtl/stream_arbiter.sv - four requesters onto one sink with bursty round-robin ownership
module stream_arbiter
  import fpu_stream_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int BURST_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  stream_arbiter_if.slave  bus
);

  localparam logic [3:0] BURST_MAX = 4'(BURST_LEN);

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       burst_cnt;
  logic [3:0]       burst_nxt;
  src_id_t          last_owner;
  src_id_t          rr_pick;
  src_id_t          pick;
  logic [3:0]       stb;
  logic [3:0]       ack;
  logic             any_req;
  logic             owner_valid;
  logic             keep_owner;
  logic             take;
  logic [WIDTH-1:0] pick_data;
  logic [WIDTH-1:0] z_data;
  src_id_t          z_src;

  assign stb = {bus.input_d_stb, bus.input_c_stb, bus.input_b_stb, bus.input_a_stb};

  rr_arbiter u_rr (
    .req   (stb),
    .last  (last_owner),
    .valid (any_req),
    .pick  (rr_pick)
  );

  // burst_cnt == 0 means nobody currently owns the sink.
  assign owner_valid = (burst_cnt != 4'd0);
  assign keep_owner  = owner_valid && stb[last_owner] && (burst_cnt < BURST_MAX);
  assign pick        = keep_owner ? last_owner : rr_pick;
  assign take        = (state == ST_IDLE) && any_req;

  always_comb begin
    case (pick)
      SRC_A:   pick_data = bus.input_a;
      SRC_B:   pick_data = bus.input_b;
      SRC_C:   pick_data = bus.input_c;
      default: pick_data = bus.input_d;
    endcase
  end

  always_comb begin
    state_nxt = state;
    burst_nxt = burst_cnt;
    ack       = 4'b0000;
    case (state)
      ST_IDLE: begin
        if (any_req) begin
          ack[pick] = rst;
          state_nxt = ST_SEND;
          if (owner_valid && (pick == last_owner)) begin
            burst_nxt = (burst_cnt < BURST_MAX) ? burst_cnt + 4'd1 : burst_cnt;
          end else begin
            burst_nxt = 4'd1;
          end
        end else begin
          burst_nxt = 4'd0;
        end
      end
      ST_SEND: begin
        if (bus.output_z_ack) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      burst_cnt  <= 4'd0;
      last_owner <= SRC_D;
      z_data     <= '0;
      z_src      <= SRC_A;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_nxt;
      if (take) begin
        z_data     <= pick_data;
        z_src      <= pick;
        last_owner <= pick;
      end
    end
  end

  assign bus.input_a_ack  = ack[0];
  assign bus.input_b_ack  = ack[1];
  assign bus.input_c_ack  = ack[2];
  assign bus.input_d_ack  = ack[3];
  assign bus.output_z     = z_data;
  assign bus.output_z_src = z_src;
  assign bus.output_z_stb = (state == ST_SEND);
  assign bus.busy         = (state != ST_IDLE);

endmodule

// File: doc/stream_arbiter.md
STREAM_ARBITER -- requirements
Module: stream_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, data width of every stream port.
REQ-002 Parameter BURST_LEN, default 4, max consecutive words granted to one requester (legal 1..15).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 input_a, input_b, input_c, input_d  input  WIDTH each  requester data words.
REQ-006 input_a_stb .. input_d_stb  input  1 each  requester word valid; held until acked.
REQ-007 input_a_ack .. input_d_ack  output  1 each  word accepted this cycle.
REQ-008 output_z  output  WIDTH  granted word toward the shared sink (e.g. file writer input).
REQ-009 output_z_src  output  2  source index of output_z (0=a,1=b,2=c,3=d).
REQ-010 output_z_stb  output  1  output_z valid.
REQ-011 output_z_ack  input  1  sink accepts word.
REQ-012 busy  output  1  high whenever state is not IDLE.

Function
REQ-013 Transfer on any port SHALL occur only in a cycle where its stb and ack are both high.
REQ-014 FSM states SHALL be IDLE and SEND only.
REQ-015 IDLE: if any input stb high, arbiter SHALL pick one requester, assert only its ack combinationally in that cycle, capture its word and index into output regs, and go to SEND next cycle.
REQ-016 IDLE with no stb SHALL stay IDLE with all input acks low.
REQ-017 SEND: output_z_stb SHALL be high, output_z/output_z_src stable, all input acks low until output_z_ack high.
REQ-018 SEND with output_z_ack high SHALL drop output_z_stb next cycle and return to IDLE; min throughput one word per 2 cycles.
REQ-019 Latency: word acked at input in cycle N SHALL appear with output_z_stb in cycle N+1.
REQ-020 Selection: if current owner's stb is high and burst_cnt < BURST_LEN, owner SHALL be reselected; otherwise round-robin starting at index after last owner, order a,b,c,d wrap.
REQ-021 burst_cnt SHALL reset to 1 on change of owner, increment on owner reselection, saturate at BURST_LEN.
REQ-022 Owner with stb low in IDLE SHALL lose ownership; next grant uses round-robin.
REQ-023 Simultaneous requests after reset (no prior owner) SHALL grant a first.
REQ-024 Input stb changes during SEND SHALL be ignored until IDLE.
REQ-025 BURST_LEN=1 SHALL yield pure round-robin.
REQ-026 Data SHALL pass unmodified; no width conversion.

Reset
REQ-027 On rst low, immediately: state IDLE, output_z_stb 0, output_z 0, output_z_src 0, busy 0, burst_cnt 0, last owner = d (so a wins first).
REQ-028 Input acks SHALL be 0 while rst low.
REQ-029 Reset during SEND SHALL discard the captured word; it SHALL NOT be re-presented.

Structure
REQ-030 Shared package fpu_stream_pkg SHALL hold the state enum, 2-bit source id type and source id constants.
REQ-031 One sub-module rr_arbiter SHALL implement the 4-way round-robin pick given request vector and last-owner index.
REQ-032 Total RTL SHALL be 120-400 lines.

Verification
REQ-033 Single source: input_b=32'h3F800000 stb held, output_z_ack tied 1 -> input_b_ack one cycle, next cycle output_z=3F800000, output_z_src=1.
REQ-034 All four stb continuously, BURST_LEN=1, ack tied 1 -> source order a,b,c,d,a, one word per 2 cycles.
REQ-035 a and c stb continuously, BURST_LEN=4 -> 4 words from a, 4 from c, repeating.
REQ-036 Sink stall: output_z_ack low 5 cycles in SEND -> output_z stable, all input acks low, transfer on 6th cycle.
REQ-037 Assert rst low during SEND with word 32'hDEADBEEF -> output_z_stb 0 same cycle, word never emitted after release, next grant goes to a.
REQ-038 Owner a drops stb after 2 words with b pending, BURST_LEN=4 -> b granted next, burst_cnt restarts at 1.
